// File: rtl/filter_out_decimator.sv
// filter_out_decimator: accumulate-and-dump averager for the filter output stream.
// Each block of 2^d_lat accepted samples is summed, shifted down by d_lat and
// pushed into a small output FIFO drained through a valid/ready port.
// The block size is latched on the first sample of every block.
// Optional build macro: FILTER_DECIM_ROUND_EN selects round-half-up before the
// shift; when undefined the shift truncates toward minus infinity.
module filter_out_decimator #(
    parameter int DATA_WIDTH     = 14,
    parameter int FRAC_WIDTH     = 6,
    parameter int MAX_DECIM_LOG2 = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  srst,
    input  logic [$clog2(MAX_DECIM_LOG2+1)-1:0]   decim_log2,
    input  logic                                  s_tvalid,
    input  logic [DATA_WIDTH-1:0]                 s_tdata,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic [DATA_WIDTH-1:0]                 m_tdata,
    output logic                                  overflow
);

    localparam int ACC_W = DATA_WIDTH + MAX_DECIM_LOG2;
    localparam int DL_W  = $clog2(MAX_DECIM_LOG2 + 1);
    localparam int CNT_W = (MAX_DECIM_LOG2 > 0) ? MAX_DECIM_LOG2 : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [DL_W-1:0]  MAX_DL    = DL_W'(MAX_DECIM_LOG2);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    // The fixed-point format only travels with the data; reject nonsense values early.
    if (FRAC_WIDTH < 0 || FRAC_WIDTH > DATA_WIDTH) begin : g_bad_frac
        $error("filter_out_decimator: FRAC_WIDTH out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("filter_out_decimator: FIFO_DEPTH must be a power of two >= 2");
    end

    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DL_W-1:0]              d_lat_q, d_lat_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic                         overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]        mem_q [FIFO_DEPTH];

    logic [DL_W-1:0]              eff_dl;
    logic                         blk_last;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      sum_rnd;
    logic [DATA_WIDTH-1:0]        result;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         push_ok;

    // Block arithmetic: pick the factor, detect the block's last sample, form the mean.
    always_comb begin
        eff_dl = d_lat_q;
        if (cnt_q == '0) begin
            eff_dl = (decim_log2 > MAX_DL) ? MAX_DL : decim_log2;
        end
        blk_last = (cnt_q == CNT_W'((32'd1 << eff_dl) - 32'd1));
        sum      = acc_q + ACC_W'($signed(s_tdata));
`ifdef FILTER_DECIM_ROUND_EN
        // Half an LSB of the shifted result; zero when d_lat is 0 so pass-through is exact.
        sum_rnd  = sum + ACC_W'((32'd1 << eff_dl) >> 1);
`else
        sum_rnd  = sum;
`endif
        result   = DATA_WIDTH'(sum_rnd >>> eff_dl);
    end

    // Next state of the accumulator, sample counter and latched factor.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        d_lat_d = d_lat_q;
        push    = 1'b0;
        if (s_tvalid) begin
            d_lat_d = eff_dl;
            if (blk_last) begin
                acc_d = '0;
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        pop        = (occ_q != '0) && m_tready;
        full       = (occ_q == OCC_FULL);
        push_ok    = push && (!full || pop);
        overflow_d = overflow_q || (push && full && !pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d      = occ_q;
        if (push_ok && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push_ok && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // State registers with synchronous reset discarding any partial block and queued results.
    always_ff @(posedge clk) begin
        if (srst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            d_lat_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            d_lat_q    <= d_lat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are never read while the occupancy is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    // Output port: head of the FIFO, forced to zero while empty.
    always_comb begin
        m_tvalid = (occ_q != '0);
        m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_filter_out_decimator.sv
// Bench for filter_out_decimator: directed plan steps then random traffic,
// every cycle compared against a block-averaging reference model.
module tb_filter_out_decimator;

    localparam int DW    = 14;
    localparam int MAXL  = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          srst;
    logic [2:0]    decim_log2;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          overflow;

    int ncmp = 0;
    int nerr = 0;

    // reference model state
    int mq[$];
    int blk[$];
    int fac = 0;
    bit m_ovf = 0;
    int got[$];

    filter_out_decimator #(
        .DATA_WIDTH(DW), .FRAC_WIDTH(6), .MAX_DECIM_LOG2(MAXL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .srst(srst), .decim_log2(decim_log2),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int block_mean(input int f);
        int s = 0;
        foreach (blk[i]) s += blk[i];
`ifdef FILTER_DECIM_ROUND_EN
        if (f > 0) s += 2 ** (f - 1);
`endif
        return int'($floor(real'(s) / real'(2 ** f)));
    endfunction

    task automatic model_edge(input bit v, input int d, input int dl, input bit rdy, input bit rst);
        bit pop;
        bit have = 0;
        int res = 0;
        if (rst) begin
            mq = {}; blk = {}; fac = 0; m_ovf = 0;
            return;
        end
        pop = (mq.size() > 0) && rdy;
        if (v) begin
            if (blk.size() == 0) fac = (dl > MAXL) ? MAXL : dl;
            blk.push_back(d);
            if (blk.size() == 2 ** fac) begin
                res  = block_mean(fac);
                have = 1;
                blk  = {};
            end
        end
        if (pop) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(res);
            else m_ovf = 1;
        end
    endtask

    task automatic cyc(input bit v, input int d, input int dl, input bit rdy, input bit rst);
        logic [DW-1:0] dv;
        dv = DW'(d);
        s_tvalid   = v;
        s_tdata    = dv;
        decim_log2 = 3'(dl);
        m_tready   = rdy;
        srst       = rst;
        #3;
        if (!rst && m_tvalid && m_tready) got.push_back(int'($signed(m_tdata)));
        @(posedge clk);
        model_edge(v, int'($signed(dv)), dl, rdy, rst);
        #1;
        chk("m_tvalid", {31'd0, m_tvalid}, (mq.size() > 0) ? 1 : 0);
        chk("m_tdata", $signed(m_tdata), (mq.size() > 0) ? mq[0] : 0);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic expect_out(input string tag, input int e);
        chk({tag, "_present"}, (got.size() > 0) ? 1 : 0, 1);
        if (got.size() > 0) chk(tag, got.pop_front(), e);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy, 0);
    endtask

    initial begin
        srst = 1; s_tvalid = 0; s_tdata = '0; decim_log2 = '0; m_tready = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("reset_m_tvalid", {31'd0, m_tvalid}, 0);
        chk("reset_overflow", {31'd0, overflow}, 0);

        // 1: pass-through
        got = {};
        for (int i = 0; i < 10; i++) cyc(1, i, 0, 1, 0);
        idle(2, 1);
        for (int i = 0; i < 10; i++) expect_out("pass", i);
        chk("pass_count", got.size(), 0);
        chk("pass_ovf", {31'd0, overflow}, 0);

        // 2: averaging
        got = {};
        for (int i = 0; i < 4; i++) cyc(1, 64, 2, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 128, 2, 1, 0);
        idle(2, 1);
        expect_out("avg_a", 64);
        expect_out("avg_b", 128);
        chk("avg_count", got.size(), 0);
        for (int i = 0; i < 4; i++) cyc(1, -8192, 2, 1, 0);
        idle(2, 1);
        expect_out("avg_neg", -8192);

        // 3: rounding
        got = {};
        cyc(1, 1, 1, 1, 0); cyc(1, 2, 1, 1, 0);
        cyc(1, -1, 1, 1, 0); cyc(1, -2, 1, 1, 0);
        idle(2, 1);
`ifdef FILTER_DECIM_ROUND_EN
        expect_out("rnd_pos", 2);
        expect_out("rnd_neg", -1);
`else
        expect_out("rnd_pos", 1);
        expect_out("rnd_neg", -2);
`endif

        // 4: backpressure and overflow
        got = {};
        for (int i = 10; i < 16; i++) cyc(1, i, 0, 0, 0);
        chk("bp_ovf_set", {31'd0, overflow}, 1);
        chk("bp_valid_held", {31'd0, m_tvalid}, 1);
        idle(6, 1);
        for (int i = 10; i < 14; i++) expect_out("bp_drain", i);
        chk("bp_count", got.size(), 0);
        chk("bp_valid_fall", {31'd0, m_tvalid}, 0);
        chk("bp_ovf_sticky", {31'd0, overflow}, 1);

        // 5: factor change mid-block
        got = {};
        cyc(1, 4, 2, 1, 0); cyc(1, 4, 2, 1, 0);
        cyc(1, 8, 0, 1, 0); cyc(1, 8, 0, 1, 0);
        cyc(1, 20, 0, 1, 0); cyc(1, 21, 0, 1, 0);
        idle(2, 1);
        expect_out("fc_a", 6);
        expect_out("fc_b", 20);
        expect_out("fc_c", 21);

        // 6: reset mid-operation
        got = {};
        for (int i = 0; i < 4; i++) cyc(1, 3, 2, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 5, 2, 0, 0);
        chk("rst_pending", {31'd0, m_tvalid}, 1);
        cyc(0, 0, 2, 0, 1);
        chk("rst_valid", {31'd0, m_tvalid}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        for (int i = 0; i < 4; i++) cyc(1, 40, 2, 1, 0);
        idle(2, 1);
        expect_out("rst_after", 40);
        chk("rst_count", got.size(), 0);

        // random traffic, including clamped factors and occasional resets
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 16383)) - 8192,
                int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
